// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory write arbiter.
// State and owner encodings are fixed so they stay legible in waveforms.
package dmem_arb_pkg;

   localparam int DEF_ADDR_W    = 7;
   localparam int DEF_DATA_W    = 256;
   localparam int DEF_MAX_BURST = 64;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GNT_CAP = 2'd1,
      GNT_SPT = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_CAP = 1'b0,
      OWN_SPT = 1'b1
   } owner_t;

endpackage

// File: rtl/dmem_write_arbiter.sv
// Burst-granular round-robin arbiter between the capture packer and the SPART
// loader for the single data-memory write port, with one registered write stage.
module dmem_write_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int MAX_BURST = DEF_MAX_BURST
) (
   input  logic              pxlclk,
   input  logic              rst_n,
   input  logic              cap_valid,
   input  logic              cap_last,
   input  logic [ADDR_W-1:0] cap_addr,
   input  logic [DATA_W-1:0] cap_data,
   output logic              cap_ready,
   input  logic              spt_valid,
   input  logic              spt_last,
   input  logic [ADDR_W-1:0] spt_addr,
   input  logic [DATA_W-1:0] spt_data,
   output logic              spt_ready,
   output logic              dmem_wren,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_data,
   output logic              busy,
   output logic              owner,
   input  logic              clr_err,
   output logic              err_overrun
);

   localparam int CNT_W = $clog2(MAX_BURST) + 1;

   arb_state_t        state;
   arb_state_t        stateNxt;
   owner_t            lastOwner;
   owner_t            ownerQ;
   logic [CNT_W-1:0]  beatCnt;
   logic              capGnt;
   logic              sptGnt;
   logic              accept;
   logic              acceptLast;
   logic              burstFull;
   logic              grantEnd;
   logic              overrunHit;
   logic              grantStart;
   logic [ADDR_W-1:0] selAddr;
   logic [DATA_W-1:0] selData;

   // Ready decodes registered state only, so valid never reaches ready combinationally.
   assign capGnt    = (state == GNT_CAP);
   assign sptGnt    = (state == GNT_SPT);
   assign cap_ready = capGnt;
   assign spt_ready = sptGnt;
   assign busy      = (state != IDLE);
   assign owner     = ownerQ;

   always_comb begin
      accept     = 1'b0;
      acceptLast = 1'b0;
      selAddr    = cap_addr;
      selData    = cap_data;
      if (capGnt) begin
         accept     = cap_valid;
         acceptLast = cap_last;
      end else if (sptGnt) begin
         accept     = spt_valid;
         acceptLast = spt_last;
         selAddr    = spt_addr;
         selData    = spt_data;
      end
   end

   // beatCnt holds beats already accepted, so this flags the MAX_BURST-th beat.
   assign burstFull  = (beatCnt == CNT_W'(MAX_BURST - 1));
   assign grantEnd   = accept & (acceptLast | burstFull);
   assign overrunHit = accept & ~acceptLast & burstFull;
   assign grantStart = (state == IDLE) & (stateNxt != IDLE);

   always_comb begin
      stateNxt = state;
      case (state)
         IDLE: begin
            if (cap_valid && (!spt_valid || lastOwner == OWN_SPT))
               stateNxt = GNT_CAP;
            else if (spt_valid)
               stateNxt = GNT_SPT;
         end
         GNT_CAP, GNT_SPT: begin
            if (grantEnd)
               stateNxt = IDLE;
         end
         default: stateNxt = IDLE;
      endcase
   end

   always_ff @(posedge pxlclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         lastOwner <= OWN_SPT;
         ownerQ    <= OWN_CAP;
         beatCnt   <= '0;
      end else begin
         state <= stateNxt;
         if (grantStart) begin
            beatCnt <= '0;
            if (stateNxt == GNT_SPT) begin
               lastOwner <= OWN_SPT;
               ownerQ    <= OWN_SPT;
            end else begin
               lastOwner <= OWN_CAP;
               ownerQ    <= OWN_CAP;
            end
         end else if (accept) begin
            beatCnt <= beatCnt + CNT_W'(1);
         end
      end
   end

   // A new overrun outranks a simultaneous clear so the event is never lost.
   always_ff @(posedge pxlclk or negedge rst_n) begin
      if (!rst_n)
         err_overrun <= 1'b0;
      else if (overrunHit)
         err_overrun <= 1'b1;
      else if (clr_err)
         err_overrun <= 1'b0;
   end

   // Write stage: strobe pulses for one cycle per accept; addr/data hold otherwise.
   always_ff @(posedge pxlclk or negedge rst_n) begin
      if (!rst_n) begin
         dmem_wren <= 1'b0;
         dmem_addr <= '0;
         dmem_data <= '0;
      end else begin
         dmem_wren <= accept;
         if (accept) begin
            dmem_addr <= selAddr;
            dmem_data <= selData;
         end
      end
   end

endmodule

// File: tb/tb_dmem_write_arbiter.sv
// Directed bench for dmem_write_arbiter: reset, bursts, round-robin ties,
// stalls, overrun handling, mid-burst reset and isolation of the idle requester.
module tb_dmem_write_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW = 7;
   localparam int DW = 256;
   localparam int WAIT_MAX = 40;

   logic          pxlclk = 1'b0;
   logic          rst_n  = 1'b0;
   logic          cap_valid = 1'b0, cap_last = 1'b0, cap_ready;
   logic [AW-1:0] cap_addr = '0;
   logic [DW-1:0] cap_data = '0;
   logic          spt_valid = 1'b0, spt_last = 1'b0, spt_ready;
   logic [AW-1:0] spt_addr = '0;
   logic [DW-1:0] spt_data = '0;
   logic          dmem_wren, busy, owner, err_overrun;
   logic          clr_err = 1'b0;
   logic [AW-1:0] dmem_addr;
   logic [DW-1:0] dmem_data;

   int nChecks = 0;
   int nPass   = 0;

   always #5 pxlclk = ~pxlclk;

   dmem_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(64)) dut (
      .pxlclk(pxlclk), .rst_n(rst_n),
      .cap_valid(cap_valid), .cap_last(cap_last), .cap_addr(cap_addr),
      .cap_data(cap_data), .cap_ready(cap_ready),
      .spt_valid(spt_valid), .spt_last(spt_last), .spt_addr(spt_addr),
      .spt_data(spt_data), .spt_ready(spt_ready),
      .dmem_wren(dmem_wren), .dmem_addr(dmem_addr), .dmem_data(dmem_data),
      .busy(busy), .owner(owner), .clr_err(clr_err), .err_overrun(err_overrun)
   );

   function automatic logic [DW-1:0] pat(input bit who, input int idx);
      logic [31:0] w;
      w = (who ? 32'h5A00_0000 : 32'hC300_0000) | 32'(idx);
      return {8{w}};
   endfunction

   task automatic tick();
      @(posedge pxlclk);
      #1;
   endtask

   // Presents one beat, waits (bounded) for the grant, and checks the write it produces.
   task automatic sendBeat(input bit who, input logic [AW-1:0] a, input int idx,
                           input bit last, input bit dropAfter);
      int waitCnt;
      waitCnt = 0;
      if (!who) begin
         cap_valid = 1'b1; cap_addr = a; cap_data = pat(0, idx); cap_last = last;
      end else begin
         spt_valid = 1'b1; spt_addr = a; spt_data = pat(1, idx); spt_last = last;
      end
      while (((!who && !cap_ready) || (who && !spt_ready)) && waitCnt < WAIT_MAX) begin
         tick();
         waitCnt++;
      end
      nChecks++;
      if (waitCnt >= WAIT_MAX) $display("FAIL grant_wait who=%0d idx=%0d: no ready after %0d cycles", who, idx, waitCnt);
      else nPass++;
      tick();
      nChecks++;
      if (dmem_wren !== 1'b1 || dmem_addr !== a || dmem_data !== pat(who, idx))
         $display("FAIL write_beat who=%0d idx=%0d: got wren=%b addr=%0d data=%h, expected wren=1 addr=%0d data=%h",
                  who, idx, dmem_wren, dmem_addr, dmem_data, a, pat(who, idx));
      else nPass++;
      if (dropAfter) begin
         if (!who) begin cap_valid = 1'b0; cap_last = 1'b0; end
         else begin spt_valid = 1'b0; spt_last = 1'b0; end
      end
   endtask

   task automatic sendBurst(input bit who, input logic [AW-1:0] base, input int n, input bit withLast);
      for (int i = 0; i < n; i++)
         sendBeat(who, base + AW'(i), i, withLast && (i == n - 1), i == n - 1);
   endtask

   task automatic doReset();
      @(negedge pxlclk);
      rst_n = 1'b0;
      @(negedge pxlclk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge pxlclk);
      #1;
      nChecks++;
      if ({dmem_wren, busy, owner, err_overrun, cap_ready, spt_ready} !== 6'b0 ||
          dmem_addr !== '0 || dmem_data !== '0)
         $display("FAIL reset_values: wren=%b busy=%b owner=%b err=%b crdy=%b srdy=%b addr=%0d, expected all 0",
                  dmem_wren, busy, owner, err_overrun, cap_ready, spt_ready, dmem_addr);
      else nPass++;
      @(negedge pxlclk);
      rst_n = 1'b1;
      tick();
      nChecks++;
      if (busy !== 1'b0 || dmem_wren !== 1'b0)
         $display("FAIL idle_after_reset: busy=%b wren=%b, expected 0 0", busy, dmem_wren);
      else nPass++;
   endtask

   task automatic test_capture_only();
      sendBurst(0, 7'd0, 49, 1'b1);
      nChecks++;
      if (busy !== 1'b0 || cap_ready !== 1'b0 || err_overrun !== 1'b0 || owner !== 1'b0)
         $display("FAIL cap_burst_end: busy=%b crdy=%b err=%b owner=%b, expected 0 0 0 0",
                  busy, cap_ready, err_overrun, owner);
      else nPass++;
      tick();
      nChecks++;
      if (dmem_wren !== 1'b0 || dmem_addr !== 7'd48)
         $display("FAIL cap_write_hold: wren=%b addr=%0d, expected 0 48", dmem_wren, dmem_addr);
      else nPass++;
   endtask

   task automatic test_tie();
      doReset();
      cap_valid = 1'b1;
      spt_valid = 1'b1; spt_addr = 7'd100; spt_data = pat(1, 0);
      tick();
      nChecks++;
      if (cap_ready !== 1'b1 || spt_ready !== 1'b0 || owner !== 1'b0)
         $display("FAIL tie_first: crdy=%b srdy=%b owner=%b, expected 1 0 0", cap_ready, spt_ready, owner);
      else nPass++;
      sendBurst(0, 7'd10, 4, 1'b1);
      nChecks++;
      if (spt_ready !== 1'b0 || busy !== 1'b0)
         $display("FAIL tie_dead_cycle: srdy=%b busy=%b, expected 0 0", spt_ready, busy);
      else nPass++;
      tick();
      nChecks++;
      if (spt_ready !== 1'b1 || owner !== 1'b1)
         $display("FAIL tie_spt_grant: srdy=%b owner=%b, expected 1 1", spt_ready, owner);
      else nPass++;
      sendBurst(1, 7'd100, 3, 1'b1);
      cap_valid = 1'b1;
      spt_valid = 1'b1;
      tick();
      nChecks++;
      if (cap_ready !== 1'b1 || spt_ready !== 1'b0 || owner !== 1'b0)
         $display("FAIL tie_second: crdy=%b srdy=%b owner=%b, expected 1 0 0", cap_ready, spt_ready, owner);
      else nPass++;
      spt_valid = 1'b0;
      sendBeat(0, 7'd20, 0, 1'b1, 1'b1);
   endtask

   task automatic test_stall();
      bit stallBad;
      cap_valid = 1'b1;
      spt_valid = 1'b1;
      tick();
      nChecks++;
      if (spt_ready !== 1'b1 || cap_ready !== 1'b0)
         $display("FAIL stall_rr_grant: srdy=%b crdy=%b, expected 1 0", spt_ready, cap_ready);
      else nPass++;
      sendBeat(1, 7'd30, 0, 1'b0, 1'b0);
      sendBeat(1, 7'd31, 1, 1'b0, 1'b1);
      cap_valid = 1'b1;
      stallBad = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (cap_ready !== 1'b0 || busy !== 1'b1 || spt_ready !== 1'b1 || dmem_wren !== 1'b0) stallBad = 1'b1;
      end
      nChecks++;
      if (stallBad)
         $display("FAIL stall_hold: crdy=%b busy=%b srdy=%b wren=%b, expected 0 1 1 0",
                  cap_ready, busy, spt_ready, dmem_wren);
      else nPass++;
      sendBeat(1, 7'd32, 2, 1'b1, 1'b1);
      nChecks++;
      if (cap_ready !== 1'b0)
         $display("FAIL stall_dead_cycle: crdy=%b, expected 0", cap_ready);
      else nPass++;
      tick();
      nChecks++;
      if (cap_ready !== 1'b1 || owner !== 1'b0)
         $display("FAIL stall_cap_after: crdy=%b owner=%b, expected 1 0", cap_ready, owner);
      else nPass++;
      sendBeat(0, 7'd40, 0, 1'b1, 1'b1);
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 63; i++) sendBeat(0, AW'(i), i, 1'b0, 1'b0);
      nChecks++;
      if (err_overrun !== 1'b0 || busy !== 1'b1)
         $display("FAIL overrun_before: err=%b busy=%b, expected 0 1", err_overrun, busy);
      else nPass++;
      sendBeat(0, 7'd63, 63, 1'b0, 1'b1);
      nChecks++;
      if (err_overrun !== 1'b1 || busy !== 1'b0 || cap_ready !== 1'b0)
         $display("FAIL overrun_release: err=%b busy=%b crdy=%b, expected 1 0 0", err_overrun, busy, cap_ready);
      else nPass++;
      for (int i = 0; i < 63; i++) sendBeat(0, AW'(i), i, 1'b0, 1'b0);
      clr_err = 1'b1;
      sendBeat(0, 7'd63, 63, 1'b0, 1'b1);
      clr_err = 1'b0;
      nChecks++;
      if (err_overrun !== 1'b1 || busy !== 1'b0)
         $display("FAIL overrun_set_priority: err=%b busy=%b, expected 1 0", err_overrun, busy);
      else nPass++;
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      nChecks++;
      if (err_overrun !== 1'b0)
         $display("FAIL overrun_clear: err=%b, expected 0", err_overrun);
      else nPass++;
   endtask

   task automatic test_reset_mid();
      sendBurst(0, 7'd0, 20, 1'b0);
      #1;
      rst_n = 1'b0;
      #1;
      nChecks++;
      if ({dmem_wren, busy, owner, err_overrun, cap_ready, spt_ready} !== 6'b0 ||
          dmem_addr !== '0 || dmem_data !== '0)
         $display("FAIL reset_mid_values: wren=%b busy=%b owner=%b err=%b crdy=%b srdy=%b addr=%0d, expected all 0",
                  dmem_wren, busy, owner, err_overrun, cap_ready, spt_ready, dmem_addr);
      else nPass++;
      cap_valid = 1'b1;
      spt_valid = 1'b1;
      @(negedge pxlclk);
      rst_n = 1'b1;
      tick();
      nChecks++;
      if (cap_ready !== 1'b1 || spt_ready !== 1'b0 || owner !== 1'b0)
         $display("FAIL reset_mid_regrant: crdy=%b srdy=%b owner=%b, expected 1 0 0", cap_ready, spt_ready, owner);
      else nPass++;
      spt_valid = 1'b0;
      sendBeat(0, 7'd5, 0, 1'b1, 1'b1);
   endtask

   task automatic test_ignored();
      bit leak;
      cap_valid = 1'b1;
      tick();
      spt_valid = 1'b1; spt_addr = 7'h7F; spt_data = pat(1, 99); spt_last = 1'b1;
      leak = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sendBeat(0, 7'h10 + AW'(i), i, i == 4, i == 4);
         if (dmem_addr === 7'h7F || dmem_data === pat(1, 99) || (i < 4 && spt_ready !== 1'b0)) leak = 1'b1;
      end
      nChecks++;
      if (leak)
         $display("FAIL ignored_leak: addr=%0d srdy=%b, expected capture addresses only", dmem_addr, spt_ready);
      else nPass++;
      tick();
      nChecks++;
      if (spt_ready !== 1'b1 || dmem_wren !== 1'b0 || dmem_addr !== 7'h14)
         $display("FAIL ignored_grant: srdy=%b wren=%b addr=%0d, expected 1 0 20", spt_ready, dmem_wren, dmem_addr);
      else nPass++;
      tick();
      spt_valid = 1'b0; spt_last = 1'b0;
      nChecks++;
      if (dmem_wren !== 1'b1 || dmem_addr !== 7'h7F || dmem_data !== pat(1, 99))
         $display("FAIL ignored_spt_write: wren=%b addr=%0d, expected 1 127", dmem_wren, dmem_addr);
      else nPass++;
   endtask

   initial begin
      test_reset();
      test_capture_only();
      test_tie();
      test_stall();
      test_overrun();
      test_reset_mid();
      test_ignored();
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
